// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter framing one byte as
// start(0), 8 data bits LSB first, optional even parity, stop(1).
//
// Parameters:
//   BIT_CYCLES  clock cycles each serial bit is held (1..255)
//   PARITY_EN   1 = even-parity bit after data, 0 = no parity bit
// Ports:
//   CLK   rising-edge clock
//   RST   synchronous active-high reset
//   DIN   parallel byte, captured when LOAD is accepted
//   LOAD  start request, honoured only while BUSY=0
//   SOUT  serial line, idles high
//   BUSY  frame in progress
//   DONE  one-cycle pulse on the cycle after the stop bit ends
module piso_tx #(
    parameter int unsigned BIT_CYCLES = 4,
    parameter int unsigned PARITY_EN  = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DIN,
    input  logic       LOAD,
    output logic       SOUT,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [7:0] RELOAD  = 8'(BIT_CYCLES - 1);
    localparam bit         HAS_PAR = (PARITY_EN != 0);

    state_t     state;
    state_t     state_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic [2:0] idx;
    logic [2:0] idx_n;
    logic [7:0] shreg;
    logic [7:0] shreg_n;
    logic       par;
    logic       par_n;
    logic       sout_n;
    logic       busy_n;
    logic       done_n;
    logic       bit_end;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            par   <= 1'b0;
            SOUT  <= 1'b1;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            par   <= par_n;
            SOUT  <= sout_n;
            BUSY  <= busy_n;
            DONE  <= done_n;
        end
    end

    // cnt counts down the cycles left in the current bit; zero marks
    // the last cycle, after which it reloads for the next bit.
    always_comb begin
        bit_end = (cnt == 8'd0);
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (LOAD) begin
                    state_n = START;
                    shreg_n = DIN;
                    par_n   = ^DIN;
                    idx_n   = 3'd0;
                    cnt_n   = RELOAD;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    cnt_n   = RELOAD;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = RELOAD;
                    if (idx == 3'd7) begin
                        state_n = HAS_PAR ? PARITY : STOP;
                    end else begin
                        idx_n   = idx + 3'd1;
                        shreg_n = {1'b0, shreg[7:1]};
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    cnt_n   = RELOAD;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    cnt_n   = 8'd0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
            end
        endcase
    end

    // Line level is decoded from the next state so the registered
    // SOUT lines up with the state register.
    always_comb begin
        sout_n = 1'b1;
        busy_n = (state_n != IDLE);
        unique case (state_n)
            IDLE:    sout_n = 1'b1;
            START:   sout_n = 1'b0;
            DATA:    sout_n = shreg_n[0];
            PARITY:  sout_n = par_n;
            STOP:    sout_n = 1'b1;
            default: sout_n = 1'b1;
        endcase
    end

endmodule
